// File: rtl/otter_muldiv_unit_if.sv
// Request/response bundle for the OTTER multiply/divide unit.
// The core side drives the master modport; the unit takes the slave modport.
interface otter_muldiv_unit_if;
    logic        START;
    logic [2:0]  FUNCT3;
    logic [31:0] SRCA;
    logic [31:0] SRCB;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;

    modport master (
        output START, FUNCT3, SRCA, SRCB,
        input  BUSY, DONE, RESULT
    );

    modport slave (
        input  START, FUNCT3, SRCA, SRCB,
        output BUSY, DONE, RESULT
    );
endinterface

// File: rtl/otter_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, DONE pulse on completion.
// Optional macro MULDIV_EARLY_OUT_EN lets trivial/special operations bypass iteration.
module otter_muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic               CLK,
    input  logic               RST,
    otter_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_busy;
    logic              w_done;
    logic              w_early;

    logic [2:0]        r_op;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_d;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic              r_neg;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_result;

    logic              w_a_sgn;
    logic              w_b_sgn;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_diff;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_q;
    logic [XLEN-1:0]   w_r;
    logic [XLEN-1:0]   w_res;
    logic              w_dz;
    logic              w_ovf;

    assign bus.BUSY   = w_busy;
    assign bus.DONE   = w_done;
    assign bus.RESULT = r_result;

`ifdef MULDIV_EARLY_OUT_EN
    // Zero operands and the signed-overflow pair need no iteration at all.
    assign w_early = (bus.SRCA == '0) || (bus.SRCB == '0) ||
                     ((bus.FUNCT3 == 3'b100 || bus.FUNCT3 == 3'b110) &&
                      bus.SRCA == {1'b1, {(XLEN-1){1'b0}}} &&
                      bus.SRCB == '1);
`else
    assign w_early = 1'b0;
`endif

    // Operand signedness and magnitudes for the op being accepted.
    always_comb begin
        w_a_sgn = 1'b0;
        w_b_sgn = 1'b0;
        unique case (bus.FUNCT3)
            3'b001, 3'b100, 3'b110: begin
                w_a_sgn = bus.SRCA[XLEN-1];
                w_b_sgn = bus.SRCB[XLEN-1];
            end
            3'b010: w_a_sgn = bus.SRCA[XLEN-1];
            default: ;
        endcase
        w_a_mag = w_a_sgn ? -bus.SRCA : bus.SRCA;
        w_b_mag = w_b_sgn ? -bus.SRCB : bus.SRCB;
    end

    // One shift-add (multiply) or restoring-subtract (divide) step.
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : '0);
        w_rem_sh = {r_hi, r_lo[XLEN-1]};
        w_diff   = w_rem_sh - {1'b0, r_d};
    end

    // Sign fix-up and special-case override, registered in FIX.
    always_comb begin
        w_prod = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
        w_q    = r_neg ? -r_lo : r_lo;
        w_r    = r_neg ? -r_hi : r_hi;
        w_dz   = r_op[2] && (r_b == '0);
        w_ovf  = (r_op == 3'b100 || r_op == 3'b110) &&
                 r_a == {1'b1, {(XLEN-1){1'b0}}} && r_b == '1;
        unique case (r_op)
            3'b000:         w_res = w_prod[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         w_res = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101: w_res = w_q;
            default:        w_res = w_r;
        endcase
        if (w_dz) begin
            w_res = r_op[1] ? r_a : '1;
        end else if (w_ovf) begin
            w_res = r_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if (r_a == '0 || r_b == '0) begin
            w_res = '0;
        end
`endif
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.START) begin
                    w_accept = 1'b1;
                    w_next   = w_early ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                w_busy = 1'b1;
                if (r_cnt == CW'(ITER - 1)) w_next = S_FIX;
            end
            S_FIX: begin
                w_busy = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                if (bus.START) begin
                    w_accept = 1'b1;
                    w_next   = w_early ? S_FIX : S_CALC;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch, iteration datapath and result register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op  <= bus.FUNCT3;
            r_a   <= bus.SRCA;
            r_b   <= bus.SRCB;
            r_d   <= bus.FUNCT3[2] ? w_b_mag : w_a_mag;
            r_lo  <= bus.FUNCT3[2] ? w_a_mag : w_b_mag;
            r_hi  <= '0;
            r_neg <= (bus.FUNCT3 == 3'b110) ? w_a_sgn : (w_a_sgn ^ w_b_sgn);
            r_cnt <= '0;
        end else if (r_state == S_CALC) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_op[2]) begin
                if (!w_diff[XLEN]) begin
                    r_hi <= w_diff[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], 1'b1};
                end else begin
                    r_hi <= w_rem_sh[XLEN-1:0];
                    r_lo <= {r_lo[XLEN-2:0], 1'b0};
                end
            end else begin
                r_hi <= w_sum[XLEN:1];
                r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
            end
        end else if (r_state == S_FIX) begin
            r_result <= w_res;
        end
    end
endmodule

// File: tb/tb_otter_muldiv_unit.sv
// Self-checking bench for otter_muldiv_unit: directed table, corner sequences,
// and random ops against a plain-arithmetic RV32M reference.
module tb_otter_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    otter_muldiv_unit_if u_if ();

    otter_muldiv_unit u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t tv[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic [31:0] r;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        case (f3)
            3'b000: begin p = ua * ub; r = p[31:0]; end
            3'b001: begin p = sa * sb; r = p[63:32]; end
            3'b010: begin p = sa * ub; r = p[63:32]; end
            3'b011: begin p = ua * ub; r = p[63:32]; end
            3'b100: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else r = $signed(a) / $signed(b);
            end
            3'b101: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                else r = $signed(a) % $signed(b);
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if (a == 0 || b == 0) return 2;
        if ((f3 == 3'b100 || f3 == 3'b110) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
`else
        if (f3 == 3'b111 && a == 32'h0 && b == 32'h0) return 34;
`endif
        return 34;
    endfunction

    // Waits for DONE, counting cycles since c0 and cycles where BUSY was low early.
    task automatic wait_done(input int c0, output int lat, output int busy_bad);
        lat = -1;
        busy_bad = 0;
        for (int k = 0; k < 200; k++) begin
            if (u_if.DONE === 1'b1) begin
                lat = cyc - c0;
                break;
            end
            if (u_if.BUSY !== 1'b1) busy_bad++;
            tick();
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int c0, lat, bb;
        logic [31:0] held;
        u_if.START  = 1'b1;
        u_if.FUNCT3 = f3;
        u_if.SRCA   = a;
        u_if.SRCB   = b;
        c0 = cyc;
        tick();
        u_if.START  = 1'b0;
        u_if.FUNCT3 = 3'($urandom);
        u_if.SRCA   = $urandom;
        u_if.SRCB   = $urandom;
        wait_done(c0, lat, bb);
        chk({nm, " latency"}, lat, ref_lat(f3, a, b));
        chk({nm, " result"}, u_if.RESULT, exp);
        chk({nm, " busy"}, bb, 0);
        held = u_if.RESULT;
        tick();
        chk({nm, " done pulse"}, {31'b0, u_if.DONE}, 32'd0);
        chk({nm, " result hold"}, u_if.RESULT, held);
    endtask

    initial begin
        int c0, lat, bb, nd;
        logic [2:0]  f3;
        logic [31:0] a, b;

        tv[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7x-3"};
        tv[1]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU max"};
        tv[2]  = '{3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, "MULHSU -1x2"};
        tv[3]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "DIV -7/2"};
        tv[4]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "REM -7/2"};
        tv[5]  = '{3'b101, 32'd100,        32'd7,         32'd14,        "DIVU 100/7"};
        tv[6]  = '{3'b111, 32'd100,        32'd7,         32'd2,         "REMU 100/7"};
        tv[7]  = '{3'b101, 32'h1234,       32'd0,         32'hFFFF_FFFF, "DIVU by 0"};
        tv[8]  = '{3'b110, 32'h1234,       32'd0,         32'h1234,      "REM by 0"};
        tv[9]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf"};
        tv[10] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "REM ovf"};

        rst         = 1'b1;
        u_if.START  = 1'b0;
        u_if.FUNCT3 = '0;
        u_if.SRCA   = '0;
        u_if.SRCB   = '0;
        tick();
        tick();
        chk("reset busy", {31'b0, u_if.BUSY}, 32'd0);
        chk("reset done", {31'b0, u_if.DONE}, 32'd0);
        chk("reset result", u_if.RESULT, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            run_op(tv[i].nm, tv[i].f3, tv[i].a, tv[i].b, tv[i].exp);
        end

        // Second START while busy must be ignored.
        u_if.START = 1'b1; u_if.FUNCT3 = 3'b000;
        u_if.SRCA = 32'd7; u_if.SRCB = 32'hFFFF_FFFD;
        c0 = cyc;
        tick();
        u_if.START = 1'b0;
        repeat (4) tick();
        u_if.START = 1'b1; u_if.FUNCT3 = 3'b101;
        u_if.SRCA = 32'd5; u_if.SRCB = 32'd9;
        tick();
        u_if.START = 1'b0;
        wait_done(c0, lat, bb);
        chk("ignore start latency", lat, 34);
        chk("ignore start result", u_if.RESULT, 32'hFFFF_FFEB);
        nd = 0;
        repeat (40) begin
            tick();
            if (u_if.DONE === 1'b1) nd++;
        end
        chk("ignore start no extra done", nd, 0);

        // START held in the DONE cycle launches a second op back-to-back.
        u_if.START = 1'b1; u_if.FUNCT3 = 3'b101;
        u_if.SRCA = 32'd100; u_if.SRCB = 32'd7;
        c0 = cyc;
        tick();
        u_if.START = 1'b0;
        wait_done(c0, lat, bb);
        chk("b2b first latency", lat, 34);
        chk("b2b first result", u_if.RESULT, 32'd14);
        u_if.START = 1'b1; u_if.FUNCT3 = 3'b111;
        tick();
        u_if.START = 1'b0;
        u_if.SRCA = 32'd55; u_if.SRCB = 32'd3;
        wait_done(c0, lat, bb);
        chk("b2b second latency", lat, 68);
        chk("b2b second result", u_if.RESULT, 32'd2);
        tick();

        // Asynchronous reset mid-iteration abandons the op.
        u_if.START = 1'b1; u_if.FUNCT3 = 3'b000;
        u_if.SRCA = 32'h10; u_if.SRCB = 32'h10;
        tick();
        u_if.START = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        #1;
        chk("mid reset busy", {31'b0, u_if.BUSY}, 32'd0);
        chk("mid reset result", u_if.RESULT, 32'd0);
        chk("mid reset done", {31'b0, u_if.DONE}, 32'd0);
        tick();
        rst = 1'b0;
        nd = 0;
        repeat (40) begin
            tick();
            if (u_if.DONE === 1'b1) nd++;
        end
        chk("mid reset no done", nd, 0);
        run_op("after reset", 3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);

        // Random ops, with frequent zero and extreme operands.
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: a = 32'd0;
                1: a = 32'h8000_0000;
                2: a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 20));
                3: b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            run_op($sformatf("rand%0d f3=%0d", i, f3), f3, a, b, ref_res(f3, a, b));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/otter_muldiv_unit.md
Name: otter_muldiv_unit

Overview:
- Multi-cycle RV32M multiply/divide execution unit for the OTTER core.
- Sits downstream of the ALU operand-select muxes and consumes the selected SRCA/SRCB operands, in parallel with the single-cycle ALU.
- Accepts one operation per START, iterates one bit per cycle, and returns RESULT with a one-cycle DONE pulse.
- The control FSM stalls the core while BUSY is high.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iterations per operation; must equal XLEN.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset; asynchronous, active-high.
- START  input  1  request; sampled on rising CLK while the unit is in IDLE or DONE state.
- FUNCT3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SRCA  input  32  operand A (multiplicand/dividend); latched at START.
- SRCB  input  32  operand B (multiplier/divisor); latched at START.
- BUSY  output  1  high while iterating.
- DONE  output  1  one-cycle pulse; RESULT is valid.
- RESULT  output  32  result; holds its value until the next DONE.

Behaviour:
- Reset: RST asserted asynchronously forces state IDLE, BUSY=0, DONE=0, RESULT=0, and clears internal registers. Reset mid-operation abandons the op; no DONE is produced.
- States:
  - IDLE: START -> CALC. FUNCT3/SRCA/SRCB latched, magnitudes and result sign computed, counter=0.
  - CALC: one iteration per cycle, counter++. At counter==ITER-1 -> FIX.
  - FIX: sign correction and special-case override; register RESULT -> DONE.
  - DONE: DONE=1 for exactly one cycle. If START is high -> CALC (back-to-back accepted, new operands latched), else -> IDLE.
- Timing: START high in cycle c -> BUSY high in cycles c+1..c+33 -> DONE high in cycle c+34, with RESULT valid from c+34 onward.
- START while BUSY is ignored, with no effect on the in-flight op. Operand changes after the START cycle are ignored.
- Multiply:
  - Shift-add on unsigned magnitudes into a 64-bit product; negate the product if the result is signed-negative.
  - MUL returns product[31:0]. MULH/MULHSU/MULHU return product[63:32].
  - Signedness: MULH signed x signed; MULHSU signed SRCA x unsigned SRCB; MULHU unsigned x unsigned.
- Divide:
  - Restoring division on magnitudes (DIV/REM signed, DIVU/REMU unsigned).
  - Quotient is negated when operand signs differ; remainder takes the dividend's sign.
- Special cases, applied in FIX regardless of iteration result:
  - Divisor == 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF returns 0x80000000; REM of the same returns 0.
- Corner cases: -2^31 magnitude is handled as unsigned 0x80000000, so no overflow occurs in magnitude conversion. MUL result is identical for all signedness choices.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: divide-by-zero, DIV/REM overflow, and any op with SRCA==0 or SRCB==0 (except divide-by-zero handling above) skip CALC. IDLE -> FIX directly, so BUSY is high only in cycle c+1 and DONE is high in cycle c+2. RESULT values are unchanged.
- Undefined: all ops use fixed latency (DONE at c+34); no early-out comparators are synthesized.

Test Plan:
- MUL SRCA=7, SRCB=0xFFFFFFFD (-3) -> DONE at c+34, RESULT=0xFFFFFFEB. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of same -> 0. Early-out build: each DONE at c+2.
- START pulsed again at c+5 with different operands -> ignored; first result returned at c+34. START held high in the DONE cycle -> second op accepted, DONE again at c+68.
- RST asserted mid-CALC at c+10 -> BUSY and RESULT drop to 0 immediately (async), no DONE; next START completes normally at its own c+34.
- Operands changed in cycle c+1 after START -> RESULT reflects the operands latched in cycle c.
